// File: rtl/fork_join_seq_if.sv
// fork_join_seq_if: config/status bundle for the fork/join sequencer.
// master drives start/stop/br_*, slave drives value/busy/join/iter (+limit I/O, FJSEQ_ITER_LIMIT_EN).
interface fork_join_seq_if #(
  parameter int NBR = 2,
  parameter int VW  = 4,
  parameter int TW  = 8
);
  logic              start;
  logic              stop;
  logic [NBR*TW-1:0] br_delay;
  logic [NBR*VW-1:0] br_value;
  logic [VW-1:0]     value;
  logic              busy;
  logic              join_pulse;
  logic [15:0]       iter_count;
`ifdef FJSEQ_ITER_LIMIT_EN
  logic [15:0]       iter_limit;
  logic              done_pulse;

  modport master (
    output start, stop, br_delay, br_value, iter_limit,
    input  value, busy, join_pulse, iter_count, done_pulse
  );
  modport slave (
    input  start, stop, br_delay, br_value, iter_limit,
    output value, busy, join_pulse, iter_count, done_pulse
  );
`else
  modport master (
    output start, stop, br_delay, br_value,
    input  value, busy, join_pulse, iter_count
  );
  modport slave (
    input  start, stop, br_delay, br_value,
    output value, busy, join_pulse, iter_count
  );
`endif
endinterface

// File: rtl/fork_join_seq.sv
// fork_join_seq: NBR-branch fork/join value sequencer; clk, rst (async high), bus (slave).
// Optional FJSEQ_ITER_LIMIT_EN adds bus.iter_limit / bus.done_pulse for a bounded run.
module fork_join_seq #(
  parameter int          NBR      = 2,
  parameter int          VW       = 4,
  parameter int          TW       = 8,
  parameter logic [VW-1:0] INIT_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  fork_join_seq_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [VW-1:0]     value_q, value_d;
  logic              busy_q, busy_d;
  logic              join_q, join_d;
  logic [15:0]       iter_q, iter_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NBR-1:0]    fired_q, fired_d;
  logic [NBR*TW-1:0] dly_q, dly_d;
  logic [NBR*VW-1:0] val_q, val_d;
`ifdef FJSEQ_ITER_LIMIT_EN
  logic              done_q, done_d;
  logic              limit_hit;
`endif

  logic [NBR-1:0] fire;
  logic           join_now;

  // A branch fires once per iteration when the timer
  // reaches its delay; delay 0 behaves as delay 1.
  always_comb begin
    logic [TW-1:0] eff;
    fire = '0;
    eff  = '0;
    for (int i = 0; i < NBR; i++) begin
      eff = dly_q[i*TW +: TW];
      if (eff == '0) eff = TW'(1);
      fire[i] = (state_q == S_RUN) &&
                !fired_q[i] &&
                (timer_q == eff);
    end
  end

  assign join_now = (|fire) && (&(fired_q | fire));

`ifdef FJSEQ_ITER_LIMIT_EN
  assign limit_hit = (bus.iter_limit != 16'd0) &&
                     (iter_q + 16'd1 == bus.iter_limit);
`endif

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    busy_d  = busy_q;
    join_d  = 1'b0;
    iter_d  = iter_q;
    timer_d = timer_q;
    fired_d = fired_q;
    dly_d   = dly_q;
    val_d   = val_q;
`ifdef FJSEQ_ITER_LIMIT_EN
    done_d  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          iter_d  = 16'd0;
          timer_d = TW'(1);
          fired_d = '0;
          dly_d   = bus.br_delay;
          val_d   = bus.br_value;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          // Abort: fires on this edge are dropped.
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          // Ascending scan: highest index wins ties.
          for (int i = 0; i < NBR; i++)
            if (fire[i]) value_d = val_q[i*VW +: VW];
          if (join_now) begin
            join_d  = 1'b1;
            iter_d  = iter_q + 16'd1;
            timer_d = TW'(1);
            fired_d = '0;
            dly_d   = bus.br_delay;
            val_d   = bus.br_value;
`ifdef FJSEQ_ITER_LIMIT_EN
            if (limit_hit) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
`endif
          end else begin
            fired_d = fired_q | fire;
            if (timer_q != '1)
              timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      value_q <= INIT_VAL;
      busy_q  <= 1'b0;
      join_q  <= 1'b0;
      iter_q  <= 16'd0;
      timer_q <= '0;
      fired_q <= '0;
      dly_q   <= '0;
      val_q   <= '0;
`ifdef FJSEQ_ITER_LIMIT_EN
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      busy_q  <= busy_d;
      join_q  <= join_d;
      iter_q  <= iter_d;
      timer_q <= timer_d;
      fired_q <= fired_d;
      dly_q   <= dly_d;
      val_q   <= val_d;
`ifdef FJSEQ_ITER_LIMIT_EN
      done_q  <= done_d;
`endif
    end
  end

  assign bus.value      = value_q;
  assign bus.busy       = busy_q;
  assign bus.join_pulse = join_q;
  assign bus.iter_count = iter_q;
`ifdef FJSEQ_ITER_LIMIT_EN
  assign bus.done_pulse = done_q;
`endif

endmodule

// File: tb/tb_fork_join_seq.sv
// tb_fork_join_seq: vector table + scoreboard bench for fork_join_seq.
// NBR=2, VW=4, TW=8, INIT_VAL=0; limit sequence only with FJSEQ_ITER_LIMIT_EN.
module tb_fork_join_seq;

  typedef struct {
    int         d0;
    int         d1;
    logic [3:0] v0;
    logic [3:0] v1;
    int         cycles;
  } vec_t;

  typedef struct {
    logic [3:0]  value;
    logic        busy;
    logic        jp;
    logic [15:0] ic;
    int          k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fork_join_seq_if #(.NBR(2), .VW(4), .TW(8)) bus ();

  fork_join_seq #(
    .NBR(2), .VW(4), .TW(8), .INIT_VAL(4'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(string nm, logic [3:0] ev, logic eb,
                     logic ej, logic [15:0] ei);
    checks++;
    if ({bus.value, bus.busy, bus.join_pulse, bus.iter_count}
        !== {ev, eb, ej, ei}) begin
      errors++;
      $display("FAIL %s: got value=%0d busy=%0b join=%0b iter=%0d, want value=%0d busy=%0b join=%0b iter=%0d",
               nm, bus.value, bus.busy, bus.join_pulse, bus.iter_count,
               ev, eb, ej, ei);
    end
  endtask

  // Reference: position within iteration, last branch to
  // have fired so far (ties to higher index), else the
  // previous iteration's final value (or 0 in the first).
  function automatic exp_t model(int k, vec_t t);
    exp_t       r;
    int         e0, e1, len, p, best;
    logic [3:0] bv;
    e0   = (t.d0 == 0) ? 1 : t.d0;
    e1   = (t.d1 == 0) ? 1 : t.d1;
    len  = (e0 > e1) ? e0 : e1;
    p    = ((k - 1) % len) + 1;
    best = -1;
    bv   = 4'd0;
    if (e0 <= p) begin best = e0; bv = t.v0; end
    if (e1 <= p && e1 >= best) begin best = e1; bv = t.v1; end
    if (best < 0)
      bv = ((k - 1) / len == 0) ? 4'd0 :
           ((e1 >= e0) ? t.v1 : t.v0);
    r.value = bv;
    r.busy  = 1'b1;
    r.jp    = ((k % len) == 0);
    r.ic    = 16'(k / len);
    r.k     = k;
    return r;
  endfunction

  task automatic do_reset(string nm);
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk(nm, 4'd0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic start_seq(vec_t t, string nm);
    @(negedge clk);
    bus.br_delay = {8'(t.d1), 8'(t.d0)};
    bus.br_value = {t.v1, t.v0};
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk(nm, 4'd0, 1'b1, 1'b0, 16'd0);
  endtask

  task automatic run_sb(vec_t t, int from, int to, string nm);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      sb.push_back(model(k, t));
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("%s E%0d", nm, e.k), e.value, e.busy, e.jp, e.ic);
    end
  endtask

  vec_t vt[6];
  vec_t t;

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.br_delay = '0;
    bus.br_value = '0;
`ifdef FJSEQ_ITER_LIMIT_EN
    bus.iter_limit = 16'd0;
`endif
    vt[0] = '{d0: 5, d1: 8, v0: 4'd1,  v1: 4'd2,  cycles: 20};
    vt[1] = '{d0: 4, d1: 4, v0: 4'd3,  v1: 4'd7,  cycles: 10};
    vt[2] = '{d0: 0, d1: 0, v0: 4'd5,  v1: 4'd9,  cycles: 6};
    vt[3] = '{d0: 3, d1: 1, v0: 4'd6,  v1: 4'd4,  cycles: 9};
    vt[4] = '{d0: 2, d1: 7, v0: 4'd10, v1: 4'd11, cycles: 15};
    vt[5] = '{d0: 1, d1: 0, v0: 4'd12, v1: 4'd13, cycles: 4};

    for (int i = 0; i < 6; i++) begin
      do_reset($sformatf("v%0d reset", i));
      start_seq(vt[i], $sformatf("v%0d E0", i));
      run_sb(vt[i], 1, vt[i].cycles, $sformatf("v%0d", i));
    end

    // stop before E6: everything holds
    t = vt[0];
    do_reset("stop reset");
    start_seq(t, "stop E0");
    run_sb(t, 1, 5, "stop");
    bus.stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop E6", 4'd1, 1'b0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    chk("stop hold", 4'd1, 1'b0, 1'b0, 16'd0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("stop beats start", 4'd1, 1'b0, 1'b0, 16'd0);

    // async reset between E6 and E7, then restart
    do_reset("rst pre");
    start_seq(t, "rst E0");
    run_sb(t, 1, 6, "rst");
    #1;
    rst = 1'b1;
    #1;
    chk("rst async", 4'd0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    start_seq(t, "rst2 E0");
    run_sb(t, 1, 9, "rst2");

    // config re-latched only at join; start in RUN ignored
    t = '{d0: 2, d1: 3, v0: 4'd1, v1: 4'd2, cycles: 0};
    do_reset("cfg reset");
    start_seq(t, "cfg E0");
    bus.br_value = {4'd6, 4'd5};
    run_sb(t, 1, 3, "cfg");
    bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("cfg E4", 4'd2, 1'b1, 1'b0, 16'd1);
    @(posedge clk); @(negedge clk);
    chk("cfg E5", 4'd5, 1'b1, 1'b0, 16'd1);
    @(posedge clk); @(negedge clk);
    chk("cfg E6", 4'd6, 1'b1, 1'b1, 16'd2);
    bus.start = 1'b0;

`ifdef FJSEQ_ITER_LIMIT_EN
    t = vt[0];
    do_reset("lim reset");
    bus.iter_limit = 16'd2;
    start_seq(t, "lim E0");
    run_sb(t, 1, 15, "lim");
    @(posedge clk); @(negedge clk);
    chk("lim E16", 4'd2, 1'b0, 1'b1, 16'd2);
    checks++;
    if (bus.done_pulse !== 1'b1) begin
      errors++;
      $display("FAIL lim done E16: got %0b want 1", bus.done_pulse);
    end
    @(posedge clk); @(negedge clk);
    chk("lim E17", 4'd2, 1'b0, 1'b0, 16'd2);
    checks++;
    if (bus.done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL lim done E17: got %0b want 0", bus.done_pulse);
    end
    bus.iter_limit = 16'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
